// File: rtl/square_envelope.sv
// Gated ADSR envelope applied to the square oscillator stream; envelope advances on sample_valid ticks.
// Latency: sample_out/out_valid register one cycle after sample_valid; env_level/env_state update on the tick edge.
// Backpressure: none; accepts a sample every clock and emits exactly one output per accepted input.
module square_envelope #(
    parameter int SAMPLE_W = 32,
    parameter int LEVEL_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                gate,
    input  logic [LEVEL_W-1:0]  attack_step,
    input  logic [LEVEL_W-1:0]  decay_step,
    input  logic [LEVEL_W-1:0]  sustain_level,
    input  logic [LEVEL_W-1:0]  release_step,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                out_valid,
    output logic [LEVEL_W-1:0]  env_level,
    output logic [2:0]          env_state
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam int PROD_W = SAMPLE_W + LEVEL_W + 1;

    state_t             state;
    state_t             state_nxt;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] level_nxt;
    logic               gate_q;
    logic               gate_rise;
    logic               gate_fall;
    logic [LEVEL_W:0]   att_sum;
    logic [LEVEL_W:0]   dec_diff;
    logic [LEVEL_W:0]   rel_diff;
    logic               dec_floor;
    logic               rel_floor;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] level_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     unused_prod_bits;

    assign gate_rise = gate & ~gate_q;
    assign gate_fall = ~gate & gate_q;

    // One extra bit so sums cannot wrap and differences expose a borrow.
    assign att_sum  = {1'b0, level} + {1'b0, attack_step};
    assign dec_diff = {1'b0, level} - {1'b0, decay_step};
    assign rel_diff = {1'b0, level} - {1'b0, release_step};

    assign dec_floor = (decay_step == '0) || dec_diff[LEVEL_W]
                       || (dec_diff[LEVEL_W-1:0] <= sustain_level);
    assign rel_floor = (release_step == '0) || rel_diff[LEVEL_W]
                       || (rel_diff[LEVEL_W-1:0] == '0);

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        if (gate_rise) begin
            state_nxt = ST_ATTACK;
        end else if (gate_fall) begin
            if (state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})
                state_nxt = ST_RELEASE;
        end else if (sample_valid) begin
            case (state)
                ST_IDLE: begin
                    level_nxt = '0;
                end
                ST_ATTACK: begin
                    if ((attack_step == '0) || (att_sum >= {1'b0, LEVEL_MAX})) begin
                        level_nxt = LEVEL_MAX;
                        state_nxt = ST_DECAY;
                    end else begin
                        level_nxt = att_sum[LEVEL_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_floor) begin
                        level_nxt = sustain_level;
                        state_nxt = ST_SUSTAIN;
                    end else begin
                        level_nxt = dec_diff[LEVEL_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    level_nxt = sustain_level;
                end
                ST_RELEASE: begin
                    if (rel_floor) begin
                        level_nxt = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        level_nxt = rel_diff[LEVEL_W-1:0];
                    end
                end
                default: begin
                    level_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Level is zero-extended so it multiplies as a non-negative gain.
    assign sample_ext = PROD_W'($signed(sample_in));
    assign level_ext  = PROD_W'({1'b0, level});
    assign prod       = sample_ext * level_ext;

    assign unused_prod_bits = ^{prod[PROD_W-1], prod[LEVEL_W-1:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            level      <= '0;
            gate_q     <= 1'b0;
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            gate_q    <= gate;
            out_valid <= sample_valid;
            if (sample_valid)
                sample_out <= prod[LEVEL_W +: SAMPLE_W];
        end
    end

    assign env_level = level;
    assign env_state = state;

endmodule
